seg_scan_ctrl: RTL

Time-multiplexed scan controller that feeds the team's eight-digit seven-segment decoder. It holds a 32-bit value (eight hex nibbles) and steps the digit select 0..7 at a programmable refresh rate. On each step it presents the matching nibble as `num` and the digit index as `sel`, which go straight to the decoder's `num`/`sel` inputs. New values are double-buffered and swapped only at a frame boundary, so a display is never torn.

---
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an eight-digit seven-segment decoder.
// Holds a 32-bit value (eight hex nibbles) and steps the digit select 0..7,
// spending CLK_DIV cycles on each digit. New values are double-buffered and
// swapped only when the scan wraps, so a frame is never torn.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         strobe: capture data_in into the pending buffer
//   data_in      value to display; nibble k is shown on digit k
//   digit_en     per-digit enable; bit k low blanks digit k
//   num          nibble for the current digit (registered)
//   sel          current digit index (registered)
//   blank        current digit disabled (registered)
//   frame_start  one-cycle pulse when sel wraps to 0
//   update_ack   one-cycle pulse when the pending value becomes displayed
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  digit_en,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        frame_start,
    output logic        update_ack
);

    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_disp;
    logic [DATA_W-1:0] r_pend;
    logic              r_pend_valid;
    logic [3:0]        r_num;
    logic [SEL_W-1:0]  r_sel;
    logic              r_blank;
    logic              r_frame_start;
    logic              r_update_ack;

    logic              w_tick;
    logic              w_wrap;
    logic              w_swap;
    logic [SEL_W-1:0]  w_sel_next;
    logic [DATA_W-1:0] w_disp_src;

    // Slot timing and frame-boundary decode
    always_comb begin
        w_tick     = (r_cnt == CNT_W'(CLK_DIV - 1));
        w_sel_next = r_sel + SEL_W'(1);
        w_wrap     = w_tick && (r_sel == SEL_W'(7));
        w_swap     = w_wrap && r_pend_valid;
        // On a swap digit 0 is taken from the pending value so it shows at once
        w_disp_src = w_swap ? r_pend : r_disp;
    end

    // Prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Pending/display buffers; a load on the swap cycle stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_swap) begin
                r_disp <= r_pend;
            end
            if (load) begin
                r_pend       <= data_in;
                r_pend_valid <= 1'b1;
            end else if (w_swap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Scan outputs, updated only on slot ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel         <= '0;
            r_num         <= '0;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
            r_update_ack  <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_update_ack  <= w_swap;
            if (w_tick) begin
                r_sel   <= w_sel_next;
                r_num   <= w_disp_src[{w_sel_next, 2'b00} +: 4];
                r_blank <= ~digit_en[w_sel_next];
            end
        end
    end

    assign num         = r_num;
    assign sel         = r_sel;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign update_ack  = r_update_ack;

endmodule
